// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling stages.
package pool_pkg;

  localparam int LANES = 16;
  localparam int DW    = 8;

  typedef logic signed [DW-1:0] lane_t;
  typedef lane_t [LANES-1:0]    beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVEN,
    ST_ODD,
    ST_FLUSH
  } pool_state_e;

  // Signed max of two lanes; ties return the common value.
  function automatic lane_t lane_max(lane_t a, lane_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
module pool_line_buf #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 128
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Write port; contents need no reset since every read follows a write.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[raddr_sel(waddr_i)] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_sel(raddr_i)];
  end

  assign rdata_o = rdata_q;

  // Address pass-through kept as a function so depth/width stay consistent.
  function automatic logic [AW-1:0] raddr_sel(input logic [AW-1:0] a);
    return a;
  endfunction

endmodule

// File: rtl/pool_vmax_stage.sv
// Vertical 2:1 max-pool: buffers even rows, emits lane-wise max with odd rows.
module pool_vmax_stage
  import pool_pkg::*;
#(
  parameter int LANES = pool_pkg::LANES,
  parameter int DW    = pool_pkg::DW,
  parameter int MAX_W = 256,
  parameter int AW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                pool_en,
  input  logic [15:0]         row_len,
  input  logic [15:0]         rows,
  input  logic                in_valid,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_row_end,
  output logic                frame_done,
  output logic                busy,
  output logic                err_cfg,
  output logic                err_beat
);

  localparam int BW     = LANES * DW;
  localparam int STAGES = 2;

  pool_state_e state_q, state_d;
  logic        pool_en_q, pool_en_d;
  logic [15:0] row_len_q, row_len_d;
  logic [15:0] rows_q, rows_d;
  logic [15:0] col_cnt_q, col_cnt_d;
  logic [15:0] row_cnt_q, row_cnt_d;
  logic        fcnt_q, fcnt_d;
  logic        frame_done_q, frame_done_d;
  logic        err_cfg_q, err_cfg_d;
  logic        err_beat_q, err_beat_d;

  logic [STAGES-1:0] vld_pipe_q;
  logic [STAGES-1:0] end_pipe_q;
  logic              pool_d1_q;
  logic [BW-1:0]     in_d1_q;
  logic [BW-1:0]     out_data_q;
  logic [BW-1:0]     rd_data;
  logic [BW-1:0]     max_data;

  logic beat_acc, last_col, last_row, emit, buf_we, buf_re, cfg_bad;

  assign beat_acc = in_valid && (state_q == ST_EVEN || state_q == ST_ODD);
  assign last_col = (col_cnt_q == row_len_q - 16'd1);
  assign last_row = ((row_cnt_q + 16'd1) == rows_q);
  // Pass-through emits every beat; pooling emits only on the odd row of a pair.
  assign emit     = beat_acc && (!pool_en_q || state_q == ST_ODD);
  assign buf_we   = beat_acc && pool_en_q && (state_q == ST_EVEN);
  assign buf_re   = beat_acc && pool_en_q && (state_q == ST_ODD);
  assign cfg_bad  = (row_len == 16'd0) || (rows == 16'd0) || (row_len > 16'(MAX_W));

  pool_line_buf #(
    .DEPTH (MAX_W),
    .AW    (AW),
    .W     (BW)
  ) u_lbuf (
    .clk     (clk),
    .we_i    (buf_we),
    .waddr_i (col_cnt_q[AW-1:0]),
    .wdata_i (in_data),
    .re_i    (buf_re),
    .raddr_i (col_cnt_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign max_data[i*DW +: DW] = lane_max(rd_data[i*DW +: DW], in_d1_q[i*DW +: DW]);
  end

  // Next-state: frame config, row/column counters, flush countdown, error flags.
  always_comb begin
    state_d      = state_q;
    pool_en_d    = pool_en_q;
    row_len_d    = row_len_q;
    rows_d       = rows_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    fcnt_d       = fcnt_q;
    frame_done_d = 1'b0;
    err_cfg_d    = err_cfg_q;
    err_beat_d   = err_beat_q | (in_valid & (state_q == ST_IDLE));
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            err_cfg_d = 1'b1;
          end else begin
            pool_en_d = pool_en;
            row_len_d = row_len;
            rows_d    = rows;
            col_cnt_d = '0;
            row_cnt_d = '0;
            fcnt_d    = 1'b0;
            state_d   = ST_EVEN;
          end
        end
      end
      ST_EVEN, ST_ODD: begin
        if (beat_acc) begin
          if (last_col) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + 16'd1;
            if (last_row)                state_d = ST_FLUSH;
            else if (state_q == ST_EVEN) state_d = ST_ODD;
            else                         state_d = ST_EVEN;
          end else begin
            col_cnt_d = col_cnt_q + 16'd1;
          end
        end
      end
      ST_FLUSH: begin
        // Two cycles let the last beat drain; done pulses on the second.
        if (!fcnt_q) begin
          fcnt_d       = 1'b1;
          frame_done_d = 1'b1;
        end else begin
          fcnt_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pool_en_q    <= 1'b0;
      row_len_q    <= '0;
      rows_q       <= '0;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      fcnt_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_cfg_q    <= 1'b0;
      err_beat_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pool_en_q    <= pool_en_d;
      row_len_q    <= row_len_d;
      rows_q       <= rows_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      fcnt_q       <= fcnt_d;
      frame_done_q <= frame_done_d;
      err_cfg_q    <= err_cfg_d;
      err_beat_q   <= err_beat_d;
    end
  end

  // Two-stage data path: stage 1 aligns input with the buffer read, stage 2 registers the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      end_pipe_q <= '0;
      pool_d1_q  <= 1'b0;
      in_d1_q    <= '0;
      out_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], emit};
      end_pipe_q <= {end_pipe_q[STAGES-2:0], emit & last_col};
      if (emit) begin
        in_d1_q   <= in_data;
        pool_d1_q <= pool_en_q;
      end
      if (vld_pipe_q[0]) out_data_q <= pool_d1_q ? max_data : in_d1_q;
    end
  end

  assign out_valid   = vld_pipe_q[STAGES-1];
  assign out_row_end = end_pipe_q[STAGES-1];
  assign out_data    = out_data_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_cfg     = err_cfg_q;
  assign err_beat    = err_beat_q;

endmodule

// File: tb/tb_pool_vmax_stage.sv
// Randomized bench for pool_vmax_stage with a frame-level scoreboard model.
module tb_pool_vmax_stage;

  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int MAX_W = 256;
  localparam int AW    = 8;
  localparam int BW    = LANES * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pool_en = 1'b0;
  logic [15:0]   row_len = '0;
  logic [15:0]   rows = '0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          out_valid, out_row_end, frame_done, busy, err_cfg, err_beat;
  logic [BW-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            t;
    logic [BW-1:0] d;
    logic          re;
  } exp_t;

  exp_t          expq[$];
  exp_t          ec;
  logic [BW-1:0] img[$];
  logic [BW-1:0] cap[$];
  int            done_cyc = -1;
  bit            chk_on = 1'b0;

  pool_vmax_stage #(.LANES(LANES), .DW(DW), .MAX_W(MAX_W), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .pool_en     (pool_en),
    .row_len     (row_len),
    .rows        (rows),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_row_end (out_row_end),
    .frame_done  (frame_done),
    .busy        (busy),
    .err_cfg     (err_cfg),
    .err_beat    (err_beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [BW-1:0] lanes(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  function automatic logic [BW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Lane-wise signed maximum computed with integer arithmetic.
  function automatic logic [BW-1:0] vmax(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      int x, y;
      x = int'($signed(a[i*8 +: 8]));
      y = int'($signed(b[i*8 +: 8]));
      r[i*8 +: 8] = (x >= y) ? a[i*8 +: 8] : b[i*8 +: 8];
    end
    return r;
  endfunction

  task automatic fill_rand(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(rnd_beat());
  endtask

  // Output scoreboard: every valid beat must match the model in data, row end and cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      if (out_valid) begin
        total++;
        cap.push_back(out_data);
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL out_extra: out_valid=1 at cyc %0d, no beat expected", cyc);
        end else begin
          ec = expq.pop_front();
          if (ec.t != cyc || ec.d !== out_data || ec.re !== out_row_end) begin
            bad++;
            $display("FAIL out_beat: cyc %0d data %0h end %0b, want cyc %0d data %0h end %0b",
                     cyc, out_data, out_row_end, ec.t, ec.d, ec.re);
          end
        end
      end else if (expq.size() > 0 && expq[0].t <= cyc) begin
        total++;
        bad++;
        ec = expq.pop_front();
        $display("FAIL out_missing: no beat at cyc %0d, want data %0h", cyc, ec.d);
      end
      total++;
      if (frame_done !== (cyc == done_cyc)) begin
        bad++;
        $display("FAIL frame_done: got %0b at cyc %0d, want pulse at cyc %0d", frame_done, cyc, done_cyc);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    done_cyc = -1;
  endtask

  // Drives one frame from img; abort_n >= 0 asserts reset after that many beats.
  task automatic run_frame(input bit pe, input int rl, input int nr, input int gap,
                           input bit sv, input int abort_n);
    exp_t e;
    int   n, idx;
    cap.delete();
    start = 1'b1; pool_en = pe; row_len = 16'(rl); rows = 16'(nr);
    if (sv) begin in_valid = 1'b1; in_data = rnd_beat(); end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("busy_after_start", BW'(busy), BW'(1));
    if (sv) chk("err_beat_start_cycle", BW'(err_beat), BW'(1));
    n = 0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < rl; c++) begin
        if (n == abort_n) begin
          in_valid = 1'b0;
          rst_n = 1'b0;
          while (expq.size() > 0 && expq[$].t > cyc) e = expq.pop_back();
          done_cyc = -1;
          @(posedge clk); #1;
          chk("rst_out_valid", BW'(out_valid), BW'(0));
          chk("rst_busy", BW'(busy), BW'(0));
          chk("rst_frame_done", BW'(frame_done), BW'(0));
          chk("rst_err_beat", BW'(err_beat), BW'(0));
          rst_n = 1'b1;
          repeat (3) begin @(posedge clk); #1; end
          return;
        end
        while ($urandom_range(99) < gap) begin
          in_valid = 1'b0; in_data = rnd_beat();
          @(posedge clk); #1;
        end
        idx = r * rl + c;
        in_valid = 1'b1; in_data = img[idx];
        e.t = cyc + 2; e.re = (c == rl - 1);
        if (!pe) begin
          e.d = img[idx]; expq.push_back(e);
        end else if (r % 2 == 1) begin
          e.d = vmax(img[idx - rl], img[idx]); expq.push_back(e);
        end
        if (r == nr - 1 && c == rl - 1) done_cyc = cyc + 2;
        n++;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) begin @(posedge clk); #1; end
    chk("frame_end_busy", BW'(busy), BW'(0));
    chk("queue_drained", BW'(expq.size()), BW'(0));
  endtask

  initial begin
    logic [BW-1:0] w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid0", BW'(out_valid), BW'(0));
    chk("rst_out_data0", out_data, '0);
    chk("rst_row_end0", BW'(out_row_end), BW'(0));
    chk("rst_frame_done0", BW'(frame_done), BW'(0));
    chk("rst_busy0", BW'(busy), BW'(0));
    chk("rst_err_cfg0", BW'(err_cfg), BW'(0));
    chk("rst_err_beat0", BW'(err_beat), BW'(0));
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #1;

    // Ramp pattern: max(c, 10-c) for c = 0..3 gives 10, 9, 8, 7.
    img.delete();
    for (int c = 0; c < 4; c++) img.push_back(lanes(8'(c)));
    for (int c = 0; c < 4; c++) img.push_back(lanes(8'(10 - c)));
    run_frame(1'b1, 4, 2, 0, 1'b0, -1);
    chk("ramp_count", BW'(cap.size()), BW'(4));
    for (int k = 0; k < 4 && k < cap.size(); k++) begin
      w = cap[k];
      chk("ramp_lane0", BW'(w[7:0]), BW'(10 - k));
      chk("ramp_lane15", BW'(w[127:120]), BW'(10 - k));
    end

    // Signed compare: -128 vs 127 in both orders, and -1 vs -128.
    img.delete();
    img.push_back(lanes(8'h80)); img.push_back(lanes(8'h7F)); img.push_back(lanes(8'hFF));
    img.push_back(lanes(8'h7F)); img.push_back(lanes(8'h80)); img.push_back(lanes(8'h80));
    run_frame(1'b1, 3, 2, 0, 1'b0, -1);
    chk("signed_count", BW'(cap.size()), BW'(3));
    if (cap.size() == 3) begin
      chk("signed_80_7f", cap[0], lanes(8'h7F));
      chk("signed_7f_80", cap[1], lanes(8'h7F));
      chk("signed_ff_80", cap[2], lanes(8'hFF));
    end

    // Odd row count: last row is consumed but produces nothing.
    fill_rand(6);
    run_frame(1'b1, 2, 3, 20, 1'b0, -1);
    chk("odd_rows_count", BW'(cap.size()), BW'(2));

    // Pass-through with input gaps.
    fill_rand(6);
    run_frame(1'b0, 3, 2, 40, 1'b0, -1);
    chk("pass_count", BW'(cap.size()), BW'(6));

    // Full-width rows.
    fill_rand(2 * MAX_W);
    run_frame(1'b1, MAX_W, 2, 0, 1'b0, -1);
    chk("maxw_count", BW'(cap.size()), BW'(MAX_W));

    // Random frames.
    for (int f = 0; f < 10; f++) begin
      int rl, nr;
      rl = $urandom_range(9, 1);
      nr = $urandom_range(5, 1);
      fill_rand(rl * nr);
      run_frame(1'($urandom_range(1)), rl, nr, $urandom_range(50), 1'b0, -1);
    end

    // Reset in the middle of an odd row, then a clean frame.
    fill_rand(16);
    run_frame(1'b1, 4, 4, 0, 1'b0, 6);
    fill_rand(8);
    run_frame(1'b1, 4, 2, 30, 1'b0, -1);
    chk("post_rst_count", BW'(cap.size()), BW'(4));

    // Configuration errors.
    start = 1'b1; row_len = 16'd4; rows = 16'd0;
    @(posedge clk); #1; start = 1'b0;
    chk("cfg_rows0_err", BW'(err_cfg), BW'(1));
    chk("cfg_rows0_busy", BW'(busy), BW'(0));
    do_reset();
    chk("cfg_rst_clear", BW'(err_cfg), BW'(0));
    start = 1'b1; row_len = 16'(MAX_W + 1); rows = 16'd2;
    @(posedge clk); #1; start = 1'b0;
    chk("cfg_len_err", BW'(err_cfg), BW'(1));
    chk("cfg_len_busy", BW'(busy), BW'(0));
    chk("cfg_len_no_beat_err", BW'(err_beat), BW'(0));
    in_valid = 1'b1; in_data = rnd_beat();
    @(posedge clk); #1; in_valid = 1'b0;
    chk("idle_beat_err", BW'(err_beat), BW'(1));
    chk("idle_beat_no_out", BW'(out_valid), BW'(0));
    do_reset();
    chk("flags_clear_cfg", BW'(err_cfg), BW'(0));
    chk("flags_clear_beat", BW'(err_beat), BW'(0));

    // Start and in_valid together: beat dropped, frame still correct.
    fill_rand(4);
    run_frame(1'b0, 2, 2, 0, 1'b1, -1);
    chk("start_beat_count", BW'(cap.size()), BW'(4));

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_vmax_stage.md
Name: pool_vmax_stage

Overview:
- Downstream of the horizontal 2:1 max-pool stage.
- Consumes its 16-lane int8 pooled stream, one pooled column per valid beat, row by row.
- Buffers each even row in a line buffer and emits the lane-wise signed max of each even/odd row pair, completing 2x2 max pooling.
- Output feeds the layer write-back stage. When pooling is disabled the stream passes through at the same latency.

Parameters:
- LANES, 16, int8 lanes per beat
- DW, 8, bits per lane
- MAX_W, 256, max pooled columns per row (line-buffer depth)
- AW, 8, line-buffer address width, clog2(MAX_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse: latch config and begin a frame
- pool_en  in  1  1 = vertical pooling, 0 = pass-through; sampled at start
- row_len  in  16  pooled columns per input row; sampled at start
- rows  in  16  input rows per frame; sampled at start
- in_valid  in  1  input beat valid
- in_data  in  LANES*DW  input beat, lane i = bits [8i+7:8i], signed
- out_valid  out  1  output beat valid
- out_data  out  LANES*DW  output beat
- out_row_end  out  1  qualifies the last beat of an output row
- frame_done  out  1  one-cycle pulse: frame complete
- busy  out  1  high from the accepted start until frame_done
- err_cfg  out  1  sticky: rejected configuration
- err_beat  out  1  sticky: in_valid seen while not busy

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0. Line-buffer contents are don't-care, because they are never read before being written in the same frame.
- FSM states: IDLE, EVEN, ODD, FLUSH.
- IDLE + start:
  - row_len == 0, rows == 0, or row_len > MAX_W: set err_cfg, stay IDLE.
  - Otherwise latch the config, clear col_cnt and row_cnt, set busy, go to EVEN.
- start while busy is ignored.
- EVEN, on each in_valid:
  - Write in_data to buffer[col_cnt]; no output.
  - At col_cnt == row_len-1: col_cnt <= 0, row_cnt++, go to ODD.
  - Exception: if that was the last row (odd rows count), go to FLUSH. The unpaired final row is dropped.
- ODD, on each in_valid:
  - Read buffer[col_cnt] (1-cycle synchronous read) and delay in_data by 1 cycle to align.
  - Cycle 2: out_data lane i = signed max(buffer lane i, in lane i), registered. Equal values give that value.
  - At row end: out_row_end = 1 on that beat, row_cnt++. Go to EVEN, or to FLUSH if row_cnt reaches rows.
- pool_en = 0:
  - Every input beat is an output row beat; no buffer use.
  - out_data = in_data delayed 2 cycles.
  - out_row_end on column row_len-1; row advance as in ODD.
- Latency: input beat at cycle t gives out_valid at t+2 in both modes. One beat per cycle is sustained; gaps in in_valid are allowed anywhere.
- FLUSH: wait 2 cycles for the pipeline to drain, pulse frame_done, clear busy, go to IDLE.
  - If rows is odd, the last valid output precedes frame_done by at least 1 cycle.
- Signed compare: 8'h80 (-128) < 8'h7F (127); 8'hFF (-1) > 8'h80.
- in_valid while not busy is dropped and sets err_beat.
- Same-cycle events:
  - start and in_valid in IDLE: the beat is dropped and err_beat is set, since busy is not yet high.
  - A beat at the FLUSH transition belongs to the previous frame only if it was counted.
- Reset mid-frame: returns to IDLE immediately. Pipeline valids, busy and both err flags clear. No frame_done.

Decomposition:
- Shared package pool_pkg:
  - LANES, DW constants
  - lane_t typedef (signed DW)
  - beat_t typedef (LANES x lane_t)
  - function lane_max (signed)
  - FSM state enum
- Sub-module pool_line_buf: simple dual-port RAM, MAX_W x LANES*DW.
  - Write port: we/waddr/wdata.
  - Read port: raddr with registered rdata.
  - Inferable as block RAM.

Test Plan:
- start, pool_en=1, row_len=4, rows=2. Even row lanes = col index; odd row lanes = 10-col.
  - Expect 4 beats at t+2 with lanes 10, 9, 8, 7... wait, max(c, 10-c) for c=0..3 gives 10, 9, 8, 7.
  - out_row_end on the 4th beat; frame_done 2 cycles after the last beat.
- Signed test: even row lanes 8'h80, odd row lanes 8'h7F → out 8'h7F. Swapped order → 8'h7F. Pair 8'hFF with 8'h80 → 8'hFF.
- rows=3, row_len=2 → 2 output beats only; the third row is accepted without output; frame_done pulses, busy drops.
- pool_en=0, row_len=3, rows=2, random data with random in_valid gaps → 6 beats identical to input, each at +2 cycles. out_row_end on beats 3 and 6.
- Config errors:
  - row_len=MAX_W+1 → err_cfg=1, busy stays 0.
  - Then in_valid → err_beat=1.
  - Then reset → both flags 0.
- Assert rst_n=0 mid-ODD row → next cycle out_valid=0, busy=0, no frame_done. A new frame after reset produces correct results.
